// File: rtl/work_dispatcher.sv
// Broadcasts a block header to NUM_PE nodes over a credit-flow NoC port and collects the winning reply.
// Optional watchdog on WAIT_RESULT is enabled by defining WORK_DISPATCHER_TIMEOUT_EN.
module work_dispatcher #(
    parameter int          NUM_PE         = 24,
    parameter int          HDR_FLITS      = 10,
    parameter int          CREDITS        = 4,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd100_000_000
) (
    input  logic                    sys_clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [64*HDR_FLITS-1:0] header,
    output logic [72:0]             putFlit,
    output logic                    EN_putFlit,
    input  logic [2:0]              getCredit,
    input  logic [72:0]             flit,
    output logic                    send_credit,
    output logic [2:0]              credit_in,
    output logic                    busy,
    output logic                    found,
    output logic                    timeout,
    output logic                    proto_err,
    output logic [31:0]             win_nonce,
    output logic [63:0]             win_clks
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND_HDR,
        S_WAIT_RESULT,
        S_RX_RESULT,
        S_DONE
    } state_t;

    localparam int              KW       = (HDR_FLITS > 1) ? $clog2(HDR_FLITS) : 1;
    localparam int              CW       = $clog2(CREDITS + 1);
    localparam logic [KW-1:0]   K_LAST   = KW'(HDR_FLITS - 1);
    localparam logic [4:0]      PE_LAST  = 5'(NUM_PE);
    localparam logic [CW-1:0]   CRED_MAX = CW'(CREDITS);

    state_t                  r_state;
    state_t                  w_state_next;
    logic [64*HDR_FLITS-1:0] r_header;
    logic [4:0]              r_pe;
    logic [KW-1:0]           r_k;
    logic [CW-1:0]           r_credits;
    logic [31:0]             r_cycles;
    logic                    r_discard;
    logic                    r_rx_nonce_pending;
    logic                    r_found;
    logic                    r_timeout;
    logic                    r_proto_err;
    logic [31:0]             r_win_nonce;
    logic [63:0]             r_win_clks;
    logic                    r_send_credit;
    logic [2:0]              r_credit_in;

    logic [63:0] w_hdr_word [HDR_FLITS];
    logic        w_accept;
    logic        w_send;
    logic        w_last_flit;
    logic        w_cred_ret;
    logic        w_watchdog;
    logic        w_rx_valid;
    logic        w_rx_tail;
    logic [63:0] w_rx_data;
    logic [4:0]  w_unused_dest;

    genvar gi;
    generate
        for (gi = 0; gi < HDR_FLITS; gi++) begin : g_hdr_word
            assign w_hdr_word[gi] = r_header[64*gi +: 64];
        end
    endgenerate

    assign w_rx_valid    = flit[72];
    assign w_rx_tail     = flit[71];
    assign w_rx_data     = flit[63:0];
    assign w_unused_dest = flit[70:66];

    assign w_accept    = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_send      = (r_state == S_SEND_HDR) && (r_credits != '0);
    assign w_last_flit = w_send && (r_k == K_LAST) && (r_pe == PE_LAST);
    assign w_cred_ret  = getCredit[2] && (getCredit[1:0] == 2'd0);

`ifdef WORK_DISPATCHER_TIMEOUT_EN
    assign w_watchdog = (r_state == S_WAIT_RESULT) && (r_cycles >= TIMEOUT_CYCLES);
    assign timeout    = r_timeout;
`else
    logic w_unused_cfg;
    assign w_watchdog   = 1'b0;
    assign timeout      = 1'b0;
    assign w_unused_cfg = ^{r_cycles, TIMEOUT_CYCLES, r_timeout};
`endif

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        EN_putFlit   = 1'b0;
        putFlit      = '0;
        busy         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_next = S_SEND_HDR;
            end
            S_SEND_HDR: begin
                busy = 1'b1;
                if (w_send) begin
                    EN_putFlit = 1'b1;
                    putFlit    = {1'b1, (r_k == K_LAST), r_pe, 2'b00, w_hdr_word[r_k]};
                    if (w_last_flit) w_state_next = S_WAIT_RESULT;
                end
            end
            S_WAIT_RESULT: begin
                busy = 1'b1;
                if (w_watchdog) begin
                    w_state_next = S_DONE;
                end else if (w_rx_valid && !r_discard && (w_rx_data == 64'h1)) begin
                    w_state_next = S_RX_RESULT;
                end
            end
            S_RX_RESULT: begin
                busy = 1'b1;
                if (w_rx_valid && !r_rx_nonce_pending) w_state_next = S_DONE;
            end
            S_DONE: begin
                if (start) w_state_next = S_SEND_HDR;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_header           <= '0;
            r_pe               <= 5'd1;
            r_k                <= '0;
            r_credits          <= CRED_MAX;
            r_cycles           <= '0;
            r_discard          <= 1'b0;
            r_rx_nonce_pending <= 1'b0;
            r_found            <= 1'b0;
            r_timeout          <= 1'b0;
            r_proto_err        <= 1'b0;
            r_win_nonce        <= '0;
            r_win_clks         <= '0;
            r_send_credit      <= 1'b0;
            r_credit_in        <= '0;
        end else begin
            // Every ejected flit is credited back one cycle later, whatever the state.
            r_send_credit <= w_rx_valid;
            r_credit_in   <= w_rx_valid ? {1'b1, flit[65:64]} : 3'd0;

            if (w_send && !w_cred_ret) begin
                r_credits <= r_credits - CW'(1);
            end else if (!w_send && w_cred_ret && (r_credits != CRED_MAX)) begin
                r_credits <= r_credits + CW'(1);
            end

            if (w_accept) begin
                r_header    <= header;
                r_pe        <= 5'd1;
                r_k         <= '0;
                r_cycles    <= '0;
                r_discard   <= 1'b0;
                r_found     <= 1'b0;
                r_timeout   <= 1'b0;
                r_proto_err <= 1'b0;
            end else begin
                if (busy && (r_cycles != 32'hFFFF_FFFF)) r_cycles <= r_cycles + 32'd1;

                if (w_send) begin
                    if (r_k == K_LAST) begin
                        r_k  <= '0;
                        r_pe <= (r_pe == PE_LAST) ? 5'd1 : r_pe + 5'd1;
                    end else begin
                        r_k <= r_k + KW'(1);
                    end
                end

                case (r_state)
                    S_WAIT_RESULT: begin
                        if (w_watchdog) begin
                            r_timeout <= 1'b1;
                        end else if (w_rx_valid) begin
                            if (r_discard) begin
                                if (w_rx_tail) r_discard <= 1'b0;
                            end else if (w_rx_data == 64'h1) begin
                                r_rx_nonce_pending <= 1'b1;
                            end else begin
                                // Unexpected packet: drop the rest of it up to its tail.
                                r_proto_err <= 1'b1;
                                r_discard   <= !w_rx_tail;
                            end
                        end
                    end
                    S_RX_RESULT: begin
                        if (w_rx_valid) begin
                            if (r_rx_nonce_pending) begin
                                r_win_nonce        <= w_rx_data[31:0];
                                r_rx_nonce_pending <= 1'b0;
                            end else begin
                                r_win_clks <= w_rx_data;
                                r_found    <= 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign found       = r_found;
    assign proto_err   = r_proto_err;
    assign win_nonce   = r_win_nonce;
    assign win_clks    = r_win_clks;
    assign send_credit = r_send_credit;
    assign credit_in   = r_credit_in;

endmodule

// File: tb/tb_work_dispatcher.sv
// Self-checking bench for work_dispatcher: randomized headers and credit returns against a flit-queue model.
module tb_work_dispatcher;

    localparam int NUM_PE    = 2;
    localparam int HDR_FLITS = 10;
    localparam int CREDITS   = 4;
    localparam int HW        = 64 * HDR_FLITS;

    logic          sys_clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [HW-1:0] header = '0;
    logic [72:0]   putFlit;
    logic          EN_putFlit;
    logic [2:0]    getCredit = '0;
    logic [72:0]   flit = '0;
    logic          send_credit;
    logic [2:0]    credit_in;
    logic          busy, found, timeout, proto_err;
    logic [31:0]   win_nonce;
    logic [63:0]   win_clks;

    work_dispatcher #(
        .NUM_PE(NUM_PE), .HDR_FLITS(HDR_FLITS), .CREDITS(CREDITS), .TIMEOUT_CYCLES(32'd100)
    ) dut (
        .sys_clk(sys_clk), .reset(reset), .start(start), .header(header),
        .putFlit(putFlit), .EN_putFlit(EN_putFlit), .getCredit(getCredit), .flit(flit),
        .send_credit(send_credit), .credit_in(credit_in), .busy(busy), .found(found),
        .timeout(timeout), .proto_err(proto_err), .win_nonce(win_nonce), .win_clks(win_clks)
    );

    always #5 sys_clk = ~sys_clk;

    int total = 0;
    int bad = 0;
    int credits = CREDITS;
    int tb_cyc = 0;
    int t_accept = 0;

    always @(posedge sys_clk) tb_cyc <= tb_cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL global_time_limit observed=running expected=finished");
        $fatal(1, "time limit");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [HW-1:0] rand_header();
        logic [HW-1:0] h;
        for (int i = 0; i < HW / 32; i++) h[32*i +: 32] = $urandom;
        return h;
    endfunction

    task automatic check_zero(input string tag);
        check({tag, "_en"}, EN_putFlit, 0);
        check({tag, "_putFlit"}, putFlit, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_found"}, found, 0);
        check({tag, "_timeout"}, timeout, 0);
        check({tag, "_proto_err"}, proto_err, 0);
        check({tag, "_nonce"}, win_nonce, 0);
        check({tag, "_clks"}, win_clks, 0);
        check({tag, "_send_credit"}, send_credit, 0);
        check({tag, "_credit_in"}, credit_in, 0);
    endtask

    // Launches a job and follows the whole header broadcast against an ordered list of expected flits.
    task automatic run_hdr(input logic [HW-1:0] hdr, input bit stall_test);
        logic [72:0] exp_q[$];
        int cyc = 0, sent = 0, hold = 0;
        bit en, ret;
        for (int p = 1; p <= NUM_PE; p++)
            for (int k = 0; k < HDR_FLITS; k++)
                exp_q.push_back({1'b1, (k == HDR_FLITS - 1), 5'(p), 2'b00, hdr[64*k +: 64]});
        header = hdr;
        start = 1'b1;
        getCredit = '0;
        while (exp_q.size() > 0 && cyc < 500) begin
            @(negedge sys_clk);
            cyc++;
            start = 1'b0;
            header = rand_header();
            if (cyc == 1) t_accept = tb_cyc;
            en = (credits > 0);
            check("busy_send", busy, 1);
            check("en_putFlit", EN_putFlit, en);
            if (en) begin
                check($sformatf("flit%0d", sent), putFlit, exp_q.pop_front());
                sent++;
                credits--;
                $display("flit %0d sent at cycle %0d", sent, cyc);
            end else begin
                check("stall_putFlit", putFlit, 0);
            end
            if (stall_test && (sent < 4 || hold < 6)) begin
                if (sent >= 4) hold++;
                ret = 1'b0;
            end else begin
                ret = (credits < CREDITS) && ($urandom_range(0, 3) != 0);
            end
            if (ret) begin
                getCredit = 3'b100;
                credits++;
            end else begin
                getCredit = ($urandom_range(0, 1) != 0) ? {1'b1, 2'($urandom_range(1, 3))} : 3'b000;
            end
            if (cyc == 7) start = 1'b1;
        end
        check("hdr_complete", exp_q.size(), 0);
        start = 1'b0;
    endtask

    task automatic drain();
        while (credits < CREDITS) begin
            @(negedge sys_clk);
            getCredit = 3'b100;
            credits++;
        end
        @(negedge sys_clk);
        getCredit = '0;
    endtask

    task automatic eject(input logic [63:0] d, input bit tail, input logic [1:0] vc);
        flit = {1'b1, tail, 5'd0, vc, d};
        @(negedge sys_clk);
        flit = '0;
        check("send_credit", send_credit, 1);
        check("credit_in", credit_in, {1'b1, vc});
        $display("ejected data=%0h tail=%0d vc=%0d", d, tail, vc);
    endtask

    initial begin
        logic [HW-1:0] h;
        logic [31:0]   nonce;
        logic [63:0]   clks;
        int            n, t, elapsed;

        reset = 1'b1;
        repeat (3) @(negedge sys_clk);
        check_zero("reset");
        reset = 1'b0;

        // Surplus credits while idle must saturate at CREDITS.
        getCredit = 3'b100;
        repeat (3) @(negedge sys_clk);
        getCredit = '0;
        check("idle_busy", busy, 0);

        run_hdr(rand_header(), 1'b0);
        drain();
        check("wait_busy", busy, 1);
        check("wait_en", EN_putFlit, 0);

        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        @(negedge sys_clk);
        check("start_ignored_busy", busy, 1);
        check("start_ignored_en", EN_putFlit, 0);

        eject(64'h1, 1'b0, 2'd0);
        eject({32'h0, 32'h1234_5678}, 1'b0, 2'd1);
        eject(64'd5000, 1'b1, 2'd2);
        check("found", found, 1);
        check("win_nonce", win_nonce, 32'h1234_5678);
        check("win_clks", win_clks, 64'd5000);
        check("done_busy", busy, 0);
        check("done_proto_err", proto_err, 0);
        @(negedge sys_clk);
        check("credit_idle", send_credit, 0);
        check("credit_in_idle", credit_in, 0);

        eject(64'h1, 1'b1, 2'd3);
        check("done_hold_found", found, 1);
        check("done_hold_nonce", win_nonce, 32'h1234_5678);
        check("done_hold_clks", win_clks, 64'd5000);

        run_hdr(rand_header(), 1'b1);
        check("found_cleared", found, 0);
        drain();

        eject(64'h7, 1'b0, 2'd0);
        eject(64'h1, 1'b1, 2'd0);
        check("proto_err", proto_err, 1);
        check("proto_found", found, 0);
        check("proto_busy", busy, 1);
        check("proto_en", EN_putFlit, 0);

        nonce = $urandom;
        clks = {$urandom, $urandom};
        eject(64'h1, 1'b0, 2'd0);
        eject({$urandom, nonce}, 1'b0, 2'd1);
        eject(clks, 1'b1, 2'd0);
        check("rand_found", found, 1);
        check("rand_nonce", win_nonce, nonce);
        check("rand_clks", win_clks, clks);
        check("proto_err_sticky", proto_err, 1);

        // Reset while the fifth header flit is on the wire.
        h = rand_header();
        header = h;
        start = 1'b1;
        n = 0;
        t = 0;
        while (n < 5 && t < 50) begin
            @(negedge sys_clk);
            t++;
            start = 1'b0;
            if (EN_putFlit === 1'b1) n++;
            getCredit = 3'b100;
        end
        check("reached_flit5", n, 5);
        check("flit5", putFlit, {1'b1, 1'b0, 5'd1, 2'b00, h[4*64 +: 64]});
        reset = 1'b1;
        getCredit = '0;
        @(negedge sys_clk);
        check_zero("mid_reset");
        reset = 1'b0;
        credits = CREDITS;

        run_hdr(rand_header(), 1'b1);
        drain();
        check("final_wait_busy", busy, 1);

`ifdef WORK_DISPATCHER_TIMEOUT_EN
        t = 0;
        while (timeout !== 1'b1 && t < 300) begin
            @(negedge sys_clk);
            t++;
        end
        elapsed = tb_cyc - t_accept;
        check("timeout_seen", timeout, 1);
        check("timeout_at_limit", (elapsed >= 100 && elapsed <= 101), 1);
        check("timeout_found", found, 0);
        check("timeout_busy", busy, 0);
`else
        repeat (5) @(negedge sys_clk);
        elapsed = tb_cyc - t_accept;
        check("no_timeout", timeout, 0);
        check("still_waiting", busy, 1);
`endif
        $display("final job waited %0d cycles since start", elapsed);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
